seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Consumer end of the hex-nibble display bus: takes NUM_HEX 4-bit digits from the info/diag viewers.
//  Drives one time-multiplexed common-anode 7-segment bank on the board.
//  Latches digits once per frame (no tearing), decodes 0-F, scans digits with inter-digit blanking.
// PARAMETERS
//  NUM_HEX    6      digits in bank; >=1
//  SCAN_DIV   50000  clocks per digit slot; > BLANK_CYC
//  BLANK_CYC  64     clocks at start of each slot with all anodes off (anti-ghost); >=1
//  AN_ACT_LOW 1      1: o_an active-low
//  SEG_ACT_LOW 1     1: o_seg/o_dp active-low
//  BRIGHT_W   4      width of i_brightness (dimming build only)
// PORTS
//  i_clock        in   1           clock
//  i_reset        in   1           reset, asynchronous, active-high
//  i_enable       in   1           1: scan; 0: bank dark, FSM idle
//  i_hex          in   4 x NUM_HEX digit nibbles, unpacked [NUM_HEX-1:0], [0] = rightmost digit
//  i_dp           in   NUM_HEX     decimal-point request per digit
//  i_brightness   in   BRIGHT_W    PWM duty (present only with SEG7_SCAN_DIMMING_EN)
//  o_an           out  NUM_HEX     anode selects, polarity per AN_ACT_LOW
//  o_seg          out  7           {g,f,e,d,c,b,a}, o_seg[0]=a, polarity per SEG_ACT_LOW
//  o_dp           out  1           decimal point, polarity per SEG_ACT_LOW
//  o_frame_start  out  1           1-cycle pulse when digit 0 slot begins (snapshot taken)
// BEHAVIOUR
//  - Reset: FSM=S_IDLE, digit idx=0, slot cnt=0, shadow regs=0.
//  - Reset values: o_an all inactive, o_seg all inactive, o_dp inactive, o_frame_start=0.
//  - FSM states and transitions:
//    - S_IDLE: cnt/idx held 0; -> S_BLANK when i_enable=1.
//    - S_BLANK: anodes off for cnt 0..BLANK_CYC-1; -> S_DRIVE.
//    - S_DRIVE: cnt BLANK_CYC..SCAN_DIV-1; at SCAN_DIV-1: cnt->0, idx++ (wrap NUM_HEX-1->0), -> S_BLANK.
//  - Snapshot:
//    - On entry to S_BLANK with idx=0, i_hex/i_dp (and i_brightness) are latched into shadow regs.
//    - Same cycle: o_frame_start=1.
//    - Input changes mid-frame are invisible until the next frame.
//  - Frame length = NUM_HEX*SCAN_DIV clocks.
//  - Outputs are registered: o_an/o_seg/o_dp/o_frame_start reflect FSM state 1 clock later.
//  - o_seg = decode(shadow[idx]).
//  - Decode, active-high values 0..F:
//    3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71; inverted when SEG_ACT_LOW.
//  - o_seg/o_dp are held inactive whenever all anodes are off.
//  - i_enable 1->0 at any point: next edge FSM=S_IDLE; outputs dark one clock later.
//  - Re-enable always restarts at digit 0 with a fresh snapshot and o_frame_start pulse.
//  - Async reset mid-slot: outputs immediately forced to reset values; no partial-slot resume.
//  - cnt width = $clog2(SCAN_DIV), idx width = max(1,$clog2(NUM_HEX)); wrap is compare-based, not power-of-2.
// CONFIGURATION
//  - SEG7_SCAN_DIMMING_EN defined:
//    - i_brightness port exists, latched at frame start.
//    - Free-running BRIGHT_W-bit pwm counter, cleared on reset.
//    - In S_DRIVE, anode active only while pwm_cnt < bright_q.
//    - Brightness 0 = dark; 2^BRIGHT_W-1 = on 15/16 (W=4).
//  - Not defined: no port, no pwm counter; anode active for all of S_DRIVE.
// STRUCTURE
//  - Package seg7_pkg: state enum {S_IDLE,S_BLANK,S_DRIVE}.
//  - seg7_pkg also holds the SEG7_TABLE[16] constant (active-high codes above).
//  - Sub-module hex_to_seg7: combinational nibble -> 7-bit active-high decode via SEG7_TABLE.
//  - Polarity inversion and registering stay in seg7_scan_driver.
// TESTING  (SCAN_DIV=8, BLANK_CYC=2, NUM_HEX=6, both polarities active-low)
//  1. Reset asserted -> o_an=6'h3F, o_seg=7'h7F, o_dp=1, o_frame_start=0; held while i_enable=0.
//  2. Enable, i_hex={5,4,3,2,1,0}, i_dp=6'b000001:
//     - Digit 0 slot: 2 clocks o_an=3F, then 6 clocks o_an=6'b111110, o_seg=7'h40, o_dp=0.
//     - o_frame_start period = 48 clocks.
//  3. Change i_hex[0] 0->8 during digit 2 -> digit 0 still shows 7'h40 until after next o_frame_start, then 7'h00.
//  4. Drop i_enable during digit 3 S_DRIVE -> o_an=3F two clocks later.
//     Re-enable -> o_frame_start pulse, digit 0 blanking first.
//  5. Sweep i_hex[0]=0..F (one per frame) -> o_seg = ~SEG7_TABLE[n]; covers b/d lower-case codes.
//  6. SEG7_SCAN_DIMMING_EN, BRIGHT_W=4: brightness 0 -> o_an never active.
//     Brightness 8 -> active exactly where pwm_cnt<8 within S_DRIVE.
//     Async reset pulse mid-S_DRIVE -> immediate reset values.

Source files
------------

// File: rtl/seg7_scan_driver_pkg.sv
// Shared types and the 0-F segment table for the 7-segment scan driver.
// Optional build macro used by the users of this package: SEG7_SCAN_DIMMING_EN.
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    // Active-high codes, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Hex-nibble display bus from the viewers to the scan driver.
// SEG7_SCAN_DIMMING_EN adds the brightness field.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int NUM_HEX = 6
`ifdef SEG7_SCAN_DIMMING_EN
    , parameter int BRIGHT_W = 4
`endif
);
    logic                i_enable;
    logic [3:0]          i_hex [NUM_HEX-1:0];
    logic [NUM_HEX-1:0]  i_dp;
`ifdef SEG7_SCAN_DIMMING_EN
    logic [BRIGHT_W-1:0] i_brightness;

    modport master (output i_enable, output i_hex, output i_dp, output i_brightness);
    modport slave  (input  i_enable, input  i_hex, input  i_dp, input  i_brightness);
`else
    modport master (output i_enable, output i_hex, output i_dp);
    modport slave  (input  i_enable, input  i_hex, input  i_dp);
`endif
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-high 7-segment code.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG7_TABLE[i_nib];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment bank driver with per-frame snapshot.
// Define SEG7_SCAN_DIMMING_EN for PWM brightness control.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_HEX     = 6,
    parameter int SCAN_DIV    = 50000,
    parameter int BLANK_CYC   = 64,
    parameter bit AN_ACT_LOW  = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b1
`ifdef SEG7_SCAN_DIMMING_EN
    , parameter int BRIGHT_W  = 4
`endif
) (
    input  logic               i_clock,
    input  logic               i_reset,
    seg7_scan_driver_if.slave  i_bus,
    output logic [NUM_HEX-1:0] o_an,
    output logic [6:0]         o_seg,
    output logic               o_dp,
    output logic               o_frame_start
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_HEX - 1);
    localparam logic [NUM_HEX-1:0] AN_OFF     = {NUM_HEX{AN_ACT_LOW}};
    localparam logic [6:0]         SEG_OFF    = {7{SEG_ACT_LOW}};

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               w_snap;
    logic [3:0]         r_hex_sh [NUM_HEX-1:0];
    logic [NUM_HEX-1:0] r_dp_sh;
    logic               w_drive_on;
    logic [NUM_HEX-1:0] w_an_act;
    logic [6:0]         w_seg_dec;
    logic               w_frame_start;
    logic [NUM_HEX-1:0] r_an;
    logic [6:0]         r_seg;
    logic               r_dp;
    logic               r_frame_start;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Snapshot is requested on every entry into the digit-0 blanking slot
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_snap      = 1'b0;
        if (!i_bus.i_enable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_snap      = 1'b1;
                end
                S_BLANK: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == BLANK_LAST)
                        w_state_nxt = S_DRIVE;
                end
                S_DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BLANK;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt = '0;
                            w_snap    = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_hex_sh <= '{default: 4'h0};
            r_dp_sh  <= '0;
        end else if (w_snap) begin
            r_hex_sh <= i_bus.i_hex;
            r_dp_sh  <= i_bus.i_dp;
        end
    end

`ifdef SEG7_SCAN_DIMMING_EN
    logic [BRIGHT_W-1:0] r_bright_q;
    logic [BRIGHT_W-1:0] r_pwm_cnt;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bright_q <= '0;
            r_pwm_cnt  <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
            if (w_snap)
                r_bright_q <= i_bus.i_brightness;
        end
    end

    assign w_drive_on = (r_state == S_DRIVE) && (r_pwm_cnt < r_bright_q);
`else
    assign w_drive_on = (r_state == S_DRIVE);
`endif

    assign w_an_act      = w_drive_on ? (NUM_HEX'(1) << r_idx) : '0;
    assign w_frame_start = (r_state == S_BLANK) && (r_idx == '0) && (r_cnt == '0);

    hex_to_seg7 u_dec (
        .i_nib (r_hex_sh[r_idx]),
        .o_seg (w_seg_dec)
    );

    // Segments and dp are forced dark whenever no anode is lit
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_an          <= AN_OFF;
            r_seg         <= SEG_OFF;
            r_dp          <= SEG_ACT_LOW;
            r_frame_start <= 1'b0;
        end else begin
            r_an          <= w_an_act ^ AN_OFF;
            r_seg         <= (w_drive_on ? w_seg_dec : 7'h00) ^ SEG_OFF;
            r_dp          <= (w_drive_on & r_dp_sh[r_idx]) ^ SEG_ACT_LOW;
            r_frame_start <= w_frame_start;
        end
    end

    assign o_an          = r_an;
    assign o_seg         = r_seg;
    assign o_dp          = r_dp;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYC=2, NUM_HEX=6, active-low).
// Builds with or without SEG7_SCAN_DIMMING_EN.
module tb_seg7_scan_driver;
    localparam int NH = 6;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = NH * SD;
    localparam logic [6:0] TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef logic [14:0] obs_t;  // {frame_start, an, seg, dp}

    logic          clk = 1'b0;
    logic          rst;
    logic [NH-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          fs;

    always #5 clk = ~clk;

`ifdef SEG7_SCAN_DIMMING_EN
    seg7_scan_driver_if #(.NUM_HEX(NH), .BRIGHT_W(4)) u_bus ();
    seg7_scan_driver #(
        .NUM_HEX(NH), .SCAN_DIV(SD), .BLANK_CYC(BC),
        .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1), .BRIGHT_W(4)
    ) dut (
`else
    seg7_scan_driver_if #(.NUM_HEX(NH)) u_bus ();
    seg7_scan_driver #(
        .NUM_HEX(NH), .SCAN_DIV(SD), .BLANK_CYC(BC),
        .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)
    ) dut (
`endif
        .i_clock       (clk),
        .i_reset       (rst),
        .i_bus         (u_bus),
        .o_an          (an),
        .o_seg         (seg),
        .o_dp          (dp),
        .o_frame_start (fs)
    );

    obs_t          exp_q [$];
    int            total = 0;
    int            bad = 0;
    logic [3:0]    tb_hex   [NH-1:0];
    logic [NH-1:0] tb_dp;
    logic [3:0]    snap_hex [NH-1:0];
    logic [NH-1:0] snap_dp;
    logic [3:0]    tb_bright;
    logic [3:0]    snap_bright;

`ifdef SEG7_SCAN_DIMMING_EN
    // Independent copy of the free-running PWM phase
    logic [3:0] pwm_m;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_m <= '0;
        else     pwm_m <= pwm_m + 4'd1;
    end
`endif

    task automatic apply();
        u_bus.i_hex = tb_hex;
        u_bus.i_dp  = tb_dp;
`ifdef SEG7_SCAN_DIMMING_EN
        u_bus.i_brightness = tb_bright;
`endif
    endtask

    task automatic check(input string tag);
        obs_t e, o;
        o = {fs, an, seg, dp};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty observed=%h", tag, o);
        end else begin
            e = exp_q.pop_front();
            assert (o === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    task automatic push_dark(input logic f);
        exp_q.push_back({f, 6'h3F, 7'h7F, 1'b1});
    endtask

    function automatic obs_t exp_slot(input int d, input int c, input logic pwm_ok);
        logic [NH-1:0] a;
        if (c < BC || !pwm_ok)
            return {(c == 0 && d == 0), 6'h3F, 7'h7F, 1'b1};
        a = ~(6'b000001 << d);
        return {1'b0, a, ~TBL[snap_hex[d]], ~snap_dp[d]};
    endfunction

    function automatic logic pwm_ok_at(input int k);
`ifdef SEG7_SCAN_DIMMING_EN
        logic [3:0] pv;
        pv = pwm_m + 4'(k);
        return pv < snap_bright;
`else
        return (k >= 0);
`endif
    endfunction

    // Called right after a negedge; the next negedge shows the new frame's first cycle
    task automatic run_frame(input int chg_cyc, input logic [3:0] chg_val);
        snap_hex    = tb_hex;
        snap_dp     = tb_dp;
        snap_bright = tb_bright;
        for (int k = 0; k < FRAME; k++)
            exp_q.push_back(exp_slot(k / SD, k % SD, pwm_ok_at(k)));
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check($sformatf("frame_d%0d_c%0d", k / SD, k % SD));
            if (k == chg_cyc) begin
                tb_hex[0] = chg_val;
                apply();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        u_bus.i_enable = 1'b0;
        for (int i = 0; i < NH; i++) tb_hex[i] = 4'h0;
        tb_dp = '0;
        tb_bright = 4'hF;
        apply();

        // Reset state and hold while disabled
        #2;
        push_dark(1'b0); check("reset_async");
        repeat (3) @(negedge clk);
        push_dark(1'b0); check("reset_hold");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_dark(1'b0); check("idle_disabled");
        end

        // Basic scan with digits 5..0 and dp on digit 0; two frames check the period
        for (int i = 0; i < NH; i++) tb_hex[i] = 4'(i);
        tb_dp = 6'b000001;
        apply();
        u_bus.i_enable = 1'b1;
        push_dark(1'b0);
        @(negedge clk); check("enable_first");
        run_frame(-1, 4'h0);
        run_frame(-1, 4'h0);

        // Mid-frame change of digit 0 is invisible until the next frame
        run_frame(2 * SD + 3, 4'h8);
        run_frame(-1, 4'h0);

        // Sweep all 16 codes through digit 0, one per frame
        for (int n = 0; n < 16; n++) run_frame(10, 4'(n));
        run_frame(-1, 4'h0);

        // Drop enable in digit 3 drive phase
        repeat (3 * SD + 5) @(negedge clk);
        u_bus.i_enable = 1'b0;
        exp_q.push_back(exp_slot(3, 5, pwm_ok_at(0)));
        @(negedge clk); check("disable_lag");
        for (int i = 0; i < 4; i++) begin
            push_dark(1'b0);
            @(negedge clk); check("disable_dark");
        end
        u_bus.i_enable = 1'b1;
        push_dark(1'b0);
        @(negedge clk); check("reenable_first");
        run_frame(-1, 4'h0);

        // Async reset in digit 1 drive phase
        repeat (SD + 4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        push_dark(1'b0); check("async_reset_now");
        @(negedge clk);
        push_dark(1'b0); check("async_reset_held");
        rst = 1'b0;
        push_dark(1'b0);
        @(negedge clk); check("reset_release_first");
        run_frame(-1, 4'h0);

`ifdef SEG7_SCAN_DIMMING_EN
        tb_bright = 4'h0;
        apply();
        run_frame(-1, 4'h0);
        tb_bright = 4'h8;
        apply();
        run_frame(-1, 4'h0);
        run_frame(-1, 4'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
